// File: rtl/noc_pkg.sv
// Shared types and packet layout for the NoC injection scheduler.
// Packet: [46:44] dest, [43:41] src, [40:5] filter (3 x 12 bit), [4:0] input spikes.
package noc_pkg;

    localparam int unsigned PKT_W     = 47;
    localparam int unsigned ADDR_W    = 3;
    localparam int unsigned PAYLOAD_W = 41;
    localparam int unsigned DEST_LSB  = 44;
    localparam int unsigned SRC_LSB   = 41;
    localparam int unsigned FILT_LSB  = 5;

    typedef struct packed {
        logic [ADDR_W-1:0] dest;
        logic [ADDR_W-1:0] src;
        logic [2:0][11:0]  filter;
        logic [4:0]        ifmap;
    } noc_pkt_t;

    typedef enum logic {
        IDLE,
        SEND
    } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request after ptr (wrapping) wins.
// The caller owns ptr and advances it to the returned index on a grant.
module rr_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx
);

    logic             found;
    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = IDX_W'((32'(ptr) + k) % N);
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/noc_inject_scheduler.sv
// Credit-gated round-robin injection scheduler for the root NoC port.
// Optional SCHED_STATS_EN adds per-requester grant counters and an IDLE stall counter.
module noc_inject_scheduler
    import noc_pkg::*;
#(
    parameter int unsigned           WIDTH      = 47,
    parameter int unsigned           WIDTH_ADDR = 3,
    parameter int unsigned           NUM_REQ    = 4,
    parameter int unsigned           CREDITS    = 2,
    parameter logic [WIDTH_ADDR-1:0] SRC_ADDR   = '0
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*WIDTH_ADDR-1:0]   req_dest,
    input  logic [NUM_REQ*PAYLOAD_W-1:0]    req_payload,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [WIDTH-1:0]                out_packet,
    input  logic [(2**WIDTH_ADDR)-1:0]      credit_ret,
    output logic                            err_credit
`ifdef SCHED_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]           grant_cnt,
    output logic [15:0]                     stall_cnt
`endif
);

    localparam int unsigned NUM_DEST = 2 ** WIDTH_ADDR;
    localparam int unsigned PTR_W    = $clog2(NUM_REQ);

    sched_state_e          state_q, state_d;
    logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
    noc_pkt_t              pkt_q, pkt_d;
    logic [2:0]            credit_q [NUM_DEST];
    logic [2:0]            credit_d [NUM_DEST];
    logic                  err_q, err_d;

    logic [NUM_REQ-1:0]    eligible;
    logic [NUM_REQ-1:0]    gnt;
    logic [PTR_W-1:0]      win_idx;
    logic [WIDTH_ADDR-1:0] win_dest;
    logic [PAYLOAD_W-1:0]  win_payload;
    logic                  grant;
    logic [NUM_DEST-1:0]   take;

    // A requester only competes if its destination still has a free buffer slot.
    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            eligible[i] = req_valid[i] &&
                          (credit_q[req_dest[i*WIDTH_ADDR +: WIDTH_ADDR]] != 3'd0);
        end
    end

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (PTR_W)
    ) u_arb (
        .req (eligible),
        .ptr (rr_ptr_q),
        .gnt (gnt),
        .idx (win_idx)
    );

    assign grant       = (state_q == IDLE) && (|eligible);
    assign win_dest    = req_dest[win_idx*WIDTH_ADDR +: WIDTH_ADDR];
    assign win_payload = req_payload[win_idx*PAYLOAD_W +: PAYLOAD_W];
    assign take        = grant ? (NUM_DEST'(1) << win_dest) : '0;

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        pkt_d    = pkt_q;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    pkt_d.dest   = win_dest;
                    pkt_d.src    = SRC_ADDR;
                    pkt_d.filter = win_payload[PAYLOAD_W-1:FILT_LSB];
                    pkt_d.ifmap  = win_payload[FILT_LSB-1:0];
                    rr_ptr_d     = win_idx;
                    state_d      = SEND;
                end
            end
            SEND: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Simultaneous take and return cancel; a return into a full counter saturates and flags.
    always_comb begin
        err_d = err_q;
        for (int unsigned d = 0; d < NUM_DEST; d++) begin
            credit_d[d] = credit_q[d];
            if (take[d] && !credit_ret[d]) begin
                credit_d[d] = credit_q[d] - 3'd1;
            end else if (credit_ret[d] && !take[d]) begin
                if (credit_q[d] == 3'(CREDITS)) err_d = 1'b1;
                else                            credit_d[d] = credit_q[d] + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= PTR_W'(NUM_REQ - 1);
            pkt_q    <= '0;
            err_q    <= 1'b0;
            for (int unsigned d = 0; d < NUM_DEST; d++) credit_q[d] <= 3'(CREDITS);
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            pkt_q    <= pkt_d;
            err_q    <= err_d;
            for (int unsigned d = 0; d < NUM_DEST; d++) credit_q[d] <= credit_d[d];
        end
    end

    // Grant is suppressed while reset is held so no transfer can complete during reset.
    assign req_ready  = (state_q == IDLE && rst_n) ? gnt : '0;
    assign out_valid  = (state_q == SEND);
    assign out_packet = pkt_q;
    assign err_credit = err_q;

`ifdef SCHED_STATS_EN
    logic [NUM_REQ*16-1:0] grant_cnt_q;
    logic [15:0]           stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (grant) begin
                grant_cnt_q[win_idx*16 +: 16] <= grant_cnt_q[win_idx*16 +: 16] + 16'd1;
            end
            if (state_q == IDLE && (|req_valid) && !(|eligible)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    assign grant_cnt = grant_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_noc_inject_scheduler.sv
// Directed self-checking bench for noc_inject_scheduler (default build, CREDITS=2).
module tb_noc_inject_scheduler;

    logic         clk;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [11:0]  req_dest;
    logic [163:0] req_payload;
    logic         out_valid;
    logic         out_ready;
    logic [46:0]  out_packet;
    logic [7:0]   credit_ret;
    logic         err_credit;

    int n_checked;
    int n_failed;

    noc_inject_scheduler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_dest    (req_dest),
        .req_payload (req_payload),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_packet  (out_packet),
        .credit_ret  (credit_ret),
        .err_credit  (err_credit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checked++;
        if (got !== exp) begin
            n_failed++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        req_valid   = '0;
        req_dest    = '0;
        req_payload = '0;
        credit_ret  = '0;
        out_ready   = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    logic [40:0] pay;
    logic [46:0] exp_pkt;
    logic [2:0]  dests [4];

    initial begin
        n_checked   = 0;
        n_failed    = 0;
        rst_n       = 1'b0;
        req_valid   = '0;
        req_dest    = '0;
        req_payload = '0;
        credit_ret  = '0;
        out_ready   = 1'b1;
        #1;
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_out_packet", 64'(out_packet), 64'd0);
        check_eq("rst_req_ready", 64'(req_ready), 64'd0);
        check_eq("rst_err_credit", 64'(err_credit), 64'd0);
        do_reset();

        // 1: single requester, one packet
        pay                 = 41'h1_2345_6789_A;
        req_dest[2:0]       = 3'd3;
        req_payload[40:0]   = pay;
        req_valid           = 4'b0001;
        settle();
        check_eq("t1_ready", 64'(req_ready), 64'b0001);
        step();
        req_valid = '0;
        exp_pkt   = {3'd3, 3'd0, pay};
        check_eq("t1_valid", 64'(out_valid), 64'd1);
        check_eq("t1_packet", 64'(out_packet), 64'(exp_pkt));
        check_eq("t1_ready_send", 64'(req_ready), 64'd0);
        check_eq("t1_credit3", 64'(dut.credit_q[3]), 64'd1);
        step();
        check_eq("t1_valid_drop", 64'(out_valid), 64'd0);
        credit_ret = 8'b0000_1000;
        step();
        credit_ret = '0;
        check_eq("t1_credit3_back", 64'(dut.credit_q[3]), 64'd2);

        // 2: all four requesters, credits echoed back
        do_reset();
        dests[0] = 3'd1; dests[1] = 3'd2; dests[2] = 3'd4; dests[3] = 3'd7;
        for (int i = 0; i < 4; i++) begin
            req_dest[i*3 +: 3]     = dests[i];
            req_payload[i*41 +: 41] = 41'h100 + 41'(i);
        end
        req_valid = 4'b1111;
        for (int g = 0; g < 6; g++) begin
            settle();
            check_eq("t2_idle_gap", 64'(out_valid), 64'd0);
            check_eq("t2_grant", 64'(req_ready), 64'(4'b0001 << (g % 4)));
            step();
            exp_pkt = {dests[g % 4], 3'd0, 41'h100 + 41'(g % 4)};
            check_eq("t2_packet", 64'(out_packet), 64'(exp_pkt));
            credit_ret = 8'(8'd1 << dests[g % 4]);
            step();
            credit_ret = '0;
        end
        req_valid = '0;
        check_eq("t2_credit1", 64'(dut.credit_q[1]), 64'd2);

        // 3: credit exhaustion on dest 5
        do_reset();
        req_dest[2:0]     = 3'd5;
        req_payload[40:0] = 41'h0_ABCD;
        req_valid         = 4'b0001;
        for (int n = 0; n < 2; n++) begin
            settle();
            check_eq("t3_grant", 64'(req_ready), 64'b0001);
            step();
            check_eq("t3_valid", 64'(out_valid), 64'd1);
            step();
        end
        check_eq("t3_credit5", 64'(dut.credit_q[5]), 64'd0);
        for (int n = 0; n < 3; n++) begin
            settle();
            check_eq("t3_stall_ready", 64'(req_ready), 64'd0);
            step();
            check_eq("t3_stall_valid", 64'(out_valid), 64'd0);
        end
        credit_ret = 8'b0010_0000;
        step();
        credit_ret = '0;
        check_eq("t3_regrant", 64'(req_ready), 64'b0001);
        step();
        check_eq("t3_third_valid", 64'(out_valid), 64'd1);
        req_valid = '0;
        step();

        // 4: back-pressure from the root router
        do_reset();
        req_dest[5:3]      = 3'd1;
        req_dest[8:6]      = 3'd2;
        req_payload[81:41] = 41'h1_1111;
        req_payload[122:82] = 41'h2_2222;
        req_valid          = 4'b0110;
        out_ready          = 1'b0;
        settle();
        check_eq("t4_first", 64'(req_ready), 64'b0010);
        step();
        exp_pkt = {3'd1, 3'd0, 41'h1_1111};
        for (int n = 0; n < 10; n++) begin
            check_eq("t4_hold_pkt", 64'(out_packet), 64'(exp_pkt));
            check_eq("t4_hold_ready", 64'(req_ready), 64'd0);
            step();
        end
        check_eq("t4_hold_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        step();
        check_eq("t4_next_req2", 64'(req_ready), 64'b0100);
        req_valid = '0;

        // 5: same-cycle take/return, then return into a full counter
        do_reset();
        req_dest[2:0]     = 3'd2;
        req_payload[40:0] = 41'h5;
        req_valid         = 4'b0001;
        credit_ret        = 8'b0000_0100;
        settle();
        check_eq("t5_grant", 64'(req_ready), 64'b0001);
        step();
        req_valid  = '0;
        credit_ret = '0;
        check_eq("t5_credit2", 64'(dut.credit_q[2]), 64'd2);
        check_eq("t5_no_err", 64'(err_credit), 64'd0);
        step();
        credit_ret = 8'b0100_0000;
        step();
        credit_ret = '0;
        check_eq("t5_err_set", 64'(err_credit), 64'd1);
        repeat (3) step();
        check_eq("t5_err_sticky", 64'(err_credit), 64'd1);
        check_eq("t5_credit6_sat", 64'(dut.credit_q[6]), 64'd2);

        // 6: asynchronous reset while a packet is pending
        do_reset();
        req_dest[2:0]     = 3'd4;
        req_dest[5:3]     = 3'd5;
        req_payload[40:0] = 41'h7;
        req_valid         = 4'b0001;
        out_ready         = 1'b0;
        step();
        check_eq("t6_send", 64'(out_valid), 64'd1);
        check_eq("t6_credit4_taken", 64'(dut.credit_q[4]), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("t6_async_valid", 64'(out_valid), 64'd0);
        check_eq("t6_credit4_restored", 64'(dut.credit_q[4]), 64'd2);
        req_valid = 4'b0011;
        out_ready = 1'b1;
        step();
        rst_n = 1'b1;
        settle();
        check_eq("t6_first_req0", 64'(req_ready), 64'b0001);
        req_valid = '0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checked, n_failed);
        $finish;
    end

endmodule
